// File: rtl/result_writeback.sv
`timescale 1ns/1ps
// Result writeback: buffers flushed result beats in a FIFO and issues them as
// addressed valid/ready memory writes, walking the m x p matrix tile by tile.
module result_writeback #(
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int BUS_WIDTH    = 256,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           m,
    input  logic [15:0]           p,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [BUS_WIDTH-1:0]  data_i,
    input  logic                  valid_i,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0]  mem_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int ELEMS      = BUS_WIDTH / DATA_WIDTH;
    localparam int CB_COUNT   = ARRAY_WIDTH / ELEMS;
    localparam int ELEM_BYTES = DATA_WIDTH / 8;
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int R_W        = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam int CB_W       = (CB_COUNT > 1) ? $clog2(CB_COUNT) : 1;
    localparam logic [ADDR_WIDTH-1:0] BEAT_STEP    = ADDR_WIDTH'(ELEMS * ELEM_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ELEM_BYTES_A = ADDR_WIDTH'(ELEM_BYTES);
    localparam logic [ADDR_WIDTH-1:0] BACK_MUL     = ADDR_WIDTH'((ARRAY_HEIGHT - 1) * ELEM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                r_state;
    logic [BUS_WIDTH-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_row_stride;
    logic [ADDR_WIDTH-1:0] r_tile_back;
    logic [R_W-1:0]        r_row;
    logic [CB_W-1:0]       r_cb;
    logic [15:0]           r_tc_elem;
    logic [15:0]           r_tr_elem;
    logic [15:0]           r_m;
    logic [15:0]           r_p;
    logic [32:0]           r_push_elems;
    logic [32:0]           r_total_elems;
    logic                  r_overflow;

    logic w_run, w_empty, w_full, w_pop, w_in_job, w_offer, w_push;
    logic w_row_last, w_cb_last, w_tc_last, w_tr_last, w_final;

    assign w_run      = (r_state == S_RUN);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop      = w_run & ~w_empty & mem_ready;
    assign w_in_job   = (r_push_elems < r_total_elems);
    assign w_offer    = w_run & valid_i & w_in_job;
    assign w_push     = w_offer & (~w_full | w_pop);
    assign w_row_last = (r_row == R_W'(ARRAY_HEIGHT - 1));
    assign w_cb_last  = (r_cb == CB_W'(CB_COUNT - 1));
    assign w_tc_last  = (({1'b0, r_tc_elem} + 17'(ARRAY_WIDTH)) == {1'b0, r_p});
    assign w_tr_last  = (({1'b0, r_tr_elem} + 17'(ARRAY_HEIGHT)) == {1'b0, r_m});
    assign w_final    = w_row_last & w_cb_last & w_tc_last & w_tr_last;

    assign mem_valid = w_run & ~w_empty;
    assign mem_data  = mem_valid ? r_fifo[r_rd_ptr] : '0;
    assign mem_addr  = r_addr;
    assign busy      = w_run;
    assign done      = (r_state == S_DONE);
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_addr        <= '0;
            r_row_stride  <= '0;
            r_tile_back   <= '0;
            r_row         <= '0;
            r_cb          <= '0;
            r_tc_elem     <= '0;
            r_tr_elem     <= '0;
            r_m           <= '0;
            r_p           <= '0;
            r_push_elems  <= '0;
            r_total_elems <= '0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_RUN;
                        r_m           <= m;
                        r_p           <= p;
                        r_addr        <= base_addr;
                        r_row_stride  <= ADDR_WIDTH'(p) * ELEM_BYTES_A;
                        r_tile_back   <= ADDR_WIDTH'(p) * BACK_MUL;
                        r_total_elems <= 33'(m) * 33'(p);
                        r_push_elems  <= '0;
                        r_row         <= '0;
                        r_cb          <= '0;
                        r_tc_elem     <= '0;
                        r_tr_elem     <= '0;
                        r_wr_ptr      <= '0;
                        r_rd_ptr      <= '0;
                        r_count       <= '0;
                        r_overflow    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_push) begin
                        r_wr_ptr     <= r_wr_ptr + 1'b1;
                        r_push_elems <= r_push_elems + 33'(ELEMS);
                    end
                    if (w_offer & w_full & ~w_pop) begin
                        r_overflow <= 1'b1;
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                    // Rows advance by one matrix row; a finished row group steps
                    // back to the tile top and over one column block, and at the
                    // right edge of the matrix the next beat lies right after.
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                        if (!w_row_last) begin
                            r_row  <= r_row + 1'b1;
                            r_addr <= r_addr + r_row_stride;
                        end else begin
                            r_row <= '0;
                            if (!w_cb_last) begin
                                r_cb   <= r_cb + 1'b1;
                                r_addr <= r_addr - r_tile_back + BEAT_STEP;
                            end else begin
                                r_cb <= '0;
                                if (!w_tc_last) begin
                                    r_tc_elem <= r_tc_elem + 16'(ARRAY_WIDTH);
                                    r_addr    <= r_addr - r_tile_back + BEAT_STEP;
                                end else begin
                                    r_tc_elem <= '0;
                                    r_tr_elem <= r_tr_elem + 16'(ARRAY_HEIGHT);
                                    r_addr    <= r_addr + BEAT_STEP;
                                end
                            end
                        end
                        if (w_final) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_writeback.sv
`timescale 1ns/1ps
// Scoreboard bench for result_writeback: stimulus queues expected writes, a
// monitor process pops and compares them on every memory handshake.
module tb_result_writeback;
    logic         clk = 1'b0;
    logic         reset, start, valid_i, mem_ready;
    logic [15:0]  m, p;
    logic [31:0]  base_addr, mem_addr;
    logic [255:0] data_i, mem_data;
    logic         mem_valid, busy, done, overflow;

    typedef struct {
        logic [31:0]  a;
        logic [255:0] d;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          done_count = 0;
    int          hs_cyc [512];
    logic [31:0] t1_addr [8];

    result_writeback dut (
        .clk(clk), .reset(reset), .start(start), .m(m), .p(p),
        .base_addr(base_addr), .data_i(data_i), .valid_i(valid_i),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [31:0] b, input int pp, input int idx);
        int tile, bt, cb, r, ntc, tc, tr;
        tile = idx / 8;
        bt   = idx % 8;
        cb   = bt / 4;
        r    = bt % 4;
        ntc  = pp / 32;
        tc   = tile % ntc;
        tr   = tile / ntc;
        return b + 32'(((tr * 4 + r) * pp + tc * 32 + cb * 16) * 2);
    endfunction

    function automatic logic [255:0] mk_data(input int tag, input int idx);
        logic [255:0] d;
        for (int k = 0; k < 16; k++) d[k*16 +: 16] = 16'(tag * 4096 + idx * 16 + k);
        return d;
    endfunction

    task automatic monitor();
        exp_t        e;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [255:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && mem_valid) begin
                    check("hold_addr", 256'(mem_addr), 256'(prev_addr));
                    check("hold_data", mem_data, prev_data);
                end
                if (done) done_count++;
                if (mem_valid && mem_ready) begin
                    check("sb_has_entry", 256'(sb.size() > 0), 256'(1));
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("beat_addr", 256'(mem_addr), 256'(e.a));
                        check("beat_data", mem_data, e.d);
                    end
                    $display("beat %0d cyc=%0d addr=%h data=%h", hs_count, cyc, mem_addr, mem_data);
                    hs_cyc[hs_count % 512] = cyc;
                    hs_count++;
                end
                prev_stall = mem_valid && !mem_ready;
                prev_addr  = mem_addr;
                prev_data  = mem_data;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input int mm, input int pp);
        base_addr = b;
        m = 16'(mm);
        p = 16'(pp);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [255:0] d, input bit expect_it, input logic [31:0] a);
        exp_t e;
        valid_i = 1'b1;
        data_i  = d;
        if (expect_it) begin
            e.a = a;
            e.d = d;
            sb.push_back(e);
        end
        tick();
        valid_i = 1'b0;
    endtask

    task automatic wait_sb_empty(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check("drain_timeout", 256'(sb.size()), 256'(0));
    endtask

    // Waits for done, checks its timing against the last handshake and that
    // it is a single pulse; returns in the usual post-edge drive phase.
    task automatic wait_done(input string tag, input int limit, input int dc0);
        int n = 0;
        int dc;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 256'(done), 256'(1));
        dc = cyc;
        check({tag, "_done_timing"}, 256'(dc), 256'(hs_cyc[(hs_count - 1) % 512] + 1));
        check({tag, "_busy_at_done"}, 256'(busy), 256'(0));
        check({tag, "_valid_at_done"}, 256'(mem_valid), 256'(0));
        @(negedge clk);
        check({tag, "_done_pulse"}, 256'(done), 256'(0));
        check({tag, "_done_count"}, 256'(done_count - dc0), 256'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs0;
        int dc0;
        t1_addr = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0,
                    32'h1020, 32'h1060, 32'h10A0, 32'h10E0};
        reset = 1'b1; start = 1'b0; valid_i = 1'b0; data_i = '0;
        m = '0; p = '0; base_addr = '0; mem_ready = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_mem_valid", 256'(mem_valid), 256'(0));
        check("rst_mem_addr", 256'(mem_addr), 256'(0));
        check("rst_mem_data", mem_data, 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_overflow", 256'(overflow), 256'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("idle_busy", 256'(busy), 256'(0));

        // Single tile, no backpressure
        mem_ready = 1'b1;
        do_start(32'h1000, 4, 32);
        check("t1_busy_after_start", 256'(busy), 256'(1));
        hs0 = hs_count;
        dc0 = done_count;
        for (int i = 0; i < 8; i++) begin
            push(mk_data(1, i), 1'b1, t1_addr[i]);
            if (i == 0) check("t1_first_word", 256'(mem_valid), 256'(1));
        end
        wait_done("t1", 20, dc0);
        check("t1_beats", 256'(hs_count - hs0), 256'(8));
        check("t1_no_bubbles", 256'(hs_cyc[(hs_count - 1) % 512] - hs_cyc[hs0 % 512]), 256'(7));
        check("t1_overflow", 256'(overflow), 256'(0));

        // Multi-tile with a 12-cycle stall and a push into a full FIFO during a pop
        mem_ready = 1'b0;
        do_start(32'h0, 8, 64);
        hs0 = hs_count;
        dc0 = done_count;
        for (int i = 0; i < 8; i++) push(mk_data(2, i), 1'b1, exp_addr(32'h0, 64, i));
        repeat (4) tick();
        check("t2_stall_overflow", 256'(overflow), 256'(0));
        check("t2_stall_valid", 256'(mem_valid), 256'(1));
        check("t2_stall_head_addr", 256'(mem_addr), 256'(0));
        mem_ready = 1'b1;
        push(mk_data(2, 8), 1'b1, exp_addr(32'h0, 64, 8));
        check("t2_full_pop_overflow", 256'(overflow), 256'(0));
        check("t2_full_pop_valid", 256'(mem_valid), 256'(1));
        for (int i = 9; i < 32; i++) push(mk_data(2, i), 1'b1, exp_addr(32'h0, 64, i));
        wait_done("t2", 40, dc0);
        check("t2_beats", 256'(hs_count - hs0), 256'(32));

        // Overflow: ninth beat into a full, stalled FIFO is dropped
        mem_ready = 1'b0;
        do_start(32'h2000, 8, 64);
        dc0 = done_count;
        for (int i = 0; i < 8; i++) push(mk_data(3, i), 1'b1, exp_addr(32'h2000, 64, i));
        check("t3_overflow_before", 256'(overflow), 256'(0));
        push(mk_data(3, 99), 1'b0, 32'h0);
        check("t3_overflow_set", 256'(overflow), 256'(1));
        repeat (2) tick();
        mem_ready = 1'b1;
        wait_sb_empty(20);
        check("t3_dropped_not_emitted", 256'(mem_valid), 256'(0));
        check("t3_overflow_sticky", 256'(overflow), 256'(1));
        for (int i = 8; i < 32; i++) push(mk_data(3, i), 1'b1, exp_addr(32'h2000, 64, i));
        wait_done("t3", 40, dc0);
        check("t3_overflow_after_done", 256'(overflow), 256'(1));

        // Reset in the middle of a job after three handshakes
        mem_ready = 1'b0;
        do_start(32'h5000, 4, 32);
        check("t4_overflow_cleared", 256'(overflow), 256'(0));
        for (int i = 0; i < 5; i++) push(mk_data(4, i), 1'b1, exp_addr(32'h5000, 32, i));
        hs0 = hs_count;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("t4_handshakes", 256'(hs_count - hs0), 256'(3));
        check("t4_rst_valid", 256'(mem_valid), 256'(0));
        check("t4_rst_busy", 256'(busy), 256'(0));
        check("t4_rst_done", 256'(done), 256'(0));
        check("t4_rst_addr", 256'(mem_addr), 256'(0));
        check("t4_rst_data", mem_data, 256'(0));
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) push(mk_data(4, 50 + i), 1'b0, 32'h0);
        check("t4_idle_ignores_valid", 256'(mem_valid), 256'(0));
        check("t4_idle_busy", 256'(busy), 256'(0));
        do_start(32'h7000, 4, 32);
        dc0 = done_count;
        for (int i = 0; i < 8; i++) push(mk_data(5, i), 1'b1, exp_addr(32'h7000, 32, i));
        wait_done("t4", 20, dc0);

        check("sb_empty_end", 256'(sb.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
